// File: rtl/fixed_mult.sv
// fixed_mult: signed two's-complement fixed-point multiplier, Q(size-frac).frac.
// Two register stages. Stage 1 captures the exact 2*size-bit product. Stage 2
// rounds half toward +inf, rescales by frac, range-checks, and registers the result.
//
// Optional feature macro: FIXED_MULT_SAT_EN
//   defined   -> out-of-range results clamp to the max/min representable value
//   undefined -> out-of-range results wrap (low size bits kept); default build
// overflow is reported the same way in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   in0/in1 are sampled this cycle
//   in0, in1   signed operands, size bits
//   product    registered rounded product, size bits
//   out_valid  product is new this cycle
//   overflow   current result was out of range (qualified by out_valid)
module fixed_mult #(
  parameter int size = 32,
  parameter int frac = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  output logic [size-1:0] product,
  output logic            out_valid,
  output logic            overflow
);

  // One extra bit above the full product so the rounding add cannot wrap.
  localparam int W = 2*size + 1;
  localparam logic signed [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] RND  = ONE << (frac-1);
  localparam logic signed [W-1:0] MAXV = (ONE << (size-1)) - ONE;
  // Bitwise inverse of 2^(size-1)-1 is -2^(size-1).
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [2*size-1:0] a_ext;
  logic signed [2*size-1:0] b_ext;
  logic signed [2*size-1:0] full;
  logic                     v1;

  logic signed [W-1:0]      r;
  logic signed [W-1:0]      s;
  logic                     ovf_hi;
  logic                     ovf_lo;
  logic [size-1:0]          res;

  // Sign-extend before multiplying; the low 2*size bits of the product are exact.
  assign a_ext = {{size{in0[size-1]}}, in0};
  assign b_ext = {{size{in1[size-1]}}, in1};

  always_comb begin
    r      = {full[2*size-1], full} + RND;
    s      = r >>> frac;
    ovf_hi = (s > MAXV);
    ovf_lo = (s < MINV);
`ifdef FIXED_MULT_SAT_EN
    if (ovf_hi) begin
      res = MAXV[size-1:0];
    end else if (ovf_lo) begin
      res = MINV[size-1:0];
    end else begin
      res = s[size-1:0];
    end
`else
    res = s[size-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      v1        <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) begin
        full <= a_ext * b_ext;
      end
      // Outputs hold their last result through idle cycles.
      if (v1) begin
        product  <= res;
        overflow <= ovf_hi | ovf_lo;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mult.sv
// Scoreboard bench for fixed_mult at size=32, frac=16. Stimulus is driven on
// the falling edge; the monitor samples 2 time units after each rising edge.
module tb_fixed_mult;

  localparam int SIZE = 32;
  localparam int FRAC = 16;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [SIZE-1:0] in0;
  logic [SIZE-1:0] in1;
  logic [SIZE-1:0] product;
  logic            out_valid;
  logic            overflow;

  fixed_mult #(.size(SIZE), .frac(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .product   (product),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] p;
    logic            o;
    int              due;
  } exp_t;

  exp_t            exp_q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic            mon_en = 1'b0;
  logic [SIZE-1:0] last_p = '0;
  logic            last_o = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, add half an LSB, floor-divide by 2^frac.
  function automatic void model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                output logic [SIZE-1:0] p, output logic o);
    longint fa, fb, full, s, maxv, minv;
    fa   = longint'($signed(a));
    fb   = longint'($signed(b));
    full = fa * fb;
    s    = (full + (longint'(1) <<< (FRAC-1))) >>> FRAC;
    maxv = (longint'(1) <<< (SIZE-1)) - 1;
    minv = -(longint'(1) <<< (SIZE-1));
    o    = (s > maxv) || (s < minv);
`ifdef FIXED_MULT_SAT_EN
    if (s > maxv)      p = maxv[SIZE-1:0];
    else if (s < minv) p = minv[SIZE-1:0];
    else               p = s[SIZE-1:0];
`else
    p = s[SIZE-1:0];
`endif
  endfunction

  // Drive one valid pair at the current falling edge and log its expected result.
  task automatic send_exp(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] p, input logic o);
    exp_t e;
    in_valid = 1'b1;
    in0      = a;
    in1      = b;
    e.p      = p;
    e.o      = o;
    e.due    = cyc + 2;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] p;
    logic            o;
    model(a, b, p, o);
    send_exp(a, b, p, o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in0      = $urandom;
      in1      = $urandom;
      @(negedge clk);
    end
  endtask

  function automatic logic [SIZE-1:0] rand_op();
    logic [SIZE-1:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0:       rand_op = v;
      1:       rand_op = {{12{v[19]}}, v[19:0]};
      2:       rand_op = {{16{v[15]}}, v[15:0]};
      default: rand_op = {{8{v[23]}}, v[23:0]};
    endcase
  endfunction

  // Monitor: pops the scoreboard on every out_valid, otherwise checks hold.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (mon_en) begin
      checks++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: cycle %0d product=%h overflow=%b with empty scoreboard",
                   cyc, product, overflow);
        end else begin
          e = exp_q.pop_front();
          if (product !== e.p || overflow !== e.o || cyc != e.due) begin
            errors++;
            $display("FAIL result: cycle %0d got product=%h overflow=%b, expected product=%h overflow=%b at cycle %0d",
                     cyc, product, overflow, e.p, e.o, e.due);
          end
          last_p = e.p;
          last_o = e.o;
        end
      end else if (out_valid !== 1'b0 || product !== last_p || overflow !== last_o) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d got out_valid=%b product=%h overflow=%b, expected 0/%h/%b",
                 cyc, out_valid, product, overflow, last_p, last_o);
      end
    end
  end

  logic [SIZE-1:0] da[10];
  logic [SIZE-1:0] db[10];
  logic [SIZE-1:0] dp[10];
  logic            dov[10];

  initial begin
    // Directed cases: {a, b, product, overflow}. Saturating build differs only on overflow rows.
    da[0] = 32'h0001_8000; db[0] = 32'h0001_0000; dp[0] = 32'h0001_8000; dov[0] = 1'b0;
    da[1] = 32'h0001_8000; db[1] = 32'h0001_8000; dp[1] = 32'h0002_4000; dov[1] = 1'b0;
    da[2] = 32'hFFFF_0000; db[2] = 32'h0001_0000; dp[2] = 32'hFFFF_0000; dov[2] = 1'b0;
    da[3] = 32'h0000_0001; db[3] = 32'h0000_8000; dp[3] = 32'h0000_0001; dov[3] = 1'b0;
    da[4] = 32'hFFFF_FFFF; db[4] = 32'h0000_8000; dp[4] = 32'h0000_0000; dov[4] = 1'b0;
    da[5] = 32'h0000_0001; db[5] = 32'h0000_7FFF; dp[5] = 32'h0000_0000; dov[5] = 1'b0;
    da[8] = 32'h8000_0000; db[8] = 32'h0001_0000; dp[8] = 32'h8000_0000; dov[8] = 1'b0;
    da[9] = 32'h0000_0000; db[9] = 32'hDEAD_BEEF; dp[9] = 32'h0000_0000; dov[9] = 1'b0;
    da[6] = 32'h7FFF_FFFF; db[6] = 32'h7FFF_FFFF; dov[6] = 1'b1;
    da[7] = 32'h8000_0000; db[7] = 32'h8000_0000; dov[7] = 1'b1;
`ifdef FIXED_MULT_SAT_EN
    dp[6] = 32'h7FFF_FFFF;
    dp[7] = 32'h7FFF_FFFF;
`else
    dp[6] = 32'hFFFF_0000;
    dp[7] = 32'h0000_0000;
`endif

    rst      = 1'b1;
    in_valid = 1'b0;
    in0      = '0;
    in1      = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) send_exp(da[i], db[i], dp[i], dov[i]);
    // Negative overflow: wraps to 0x00008000, clamps to 0x80000000.
`ifdef FIXED_MULT_SAT_EN
    send_exp(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
`else
    send_exp(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_8000, 1'b1);
`endif
    send_exp(32'h1234_5678, 32'h0001_0000, 32'h1234_5678, 1'b0);
    idle(3);

    // Burst of five, then a one-cycle gap between pairs.
    for (int i = 0; i < 5; i++) send(rand_op(), rand_op());
    send(rand_op(), rand_op());
    idle(1);
    send(rand_op(), rand_op());
    idle(3);

    // Reset while pairs are in flight: both pairs are dropped.
    send_exp(32'h0003_0000, 32'h0002_0000, 32'h0006_0000, 1'b0);
    in_valid = 1'b1;
    in0      = 32'h0005_0000;
    in1      = 32'h0002_0000;
    rst      = 1'b1;
    exp_q.delete();
    last_p   = '0;
    last_o   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send(32'h0002_8000, 32'hFFFE_0000);
    idle(3);

    // Random traffic with random valid gaps and garbage operands when idle.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) send(rand_op(), rand_op());
      else idle(1);
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
